// File: rtl/fp16_pkg.sv
// Shared binary16 format definitions and op encodings for the fp16 add/multiply unit.
package fp16_pkg;

  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;
  localparam int BIAS   = 15;

  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam logic [15:0] POS_INF = 16'h7C00;
  localparam logic [15:0] NEG_INF = 16'hFC00;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp16_t;

endpackage

// File: rtl/fp16_add_mul_if.sv
// Operand/result bundle for the fp16 add/multiply unit; no backpressure path exists.
interface fp16_add_mul_if;
  import fp16_pkg::*;

  logic  in_valid;
  logic  op;
  fp16_t a;
  fp16_t b;
  logic  out_valid;
  fp16_t s;

  modport master (output in_valid, op, a, b, input out_valid, s);
  modport slave  (input in_valid, op, a, b, output out_valid, s);
endinterface

// File: rtl/fp16_round_pack.sv
// Round-to-nearest-even, overflow to Inf, flush-to-zero underflow and packing of a
// normalised significand {1.frac[9:0], guard, round, sticky} with an unbiased exponent.
module fp16_round_pack
  import fp16_pkg::*;
(
  input  logic              sign,
  input  logic              zero,
  input  logic signed [7:0] exp,
  input  logic [13:0]       sig,
  output fp16_t             res
);

  logic              up;
  logic [11:0]       rnd;
  logic signed [8:0] bexp;

  always_comb begin
    up   = sig[2] & (sig[1] | sig[0] | sig[3]);
    rnd  = {1'b0, sig[13:3]} + {11'b0, up};
    // rounding carry leaves 1.000..0, so the exponent steps up by one
    bexp = {exp[7], exp} + 9'(BIAS) + {8'b0, rnd[11]};

    res = {sign, 15'b0};
    if (zero || bexp < 9'sd1) begin
      res = {sign, 15'b0};
    end else if (bexp >= 9'sd31) begin
      res = sign ? NEG_INF : POS_INF;
    end else begin
      res.sign = sign;
      res.exp  = bexp[4:0];
      res.frac = rnd[11] ? rnd[10:1] : rnd[9:0];
    end
  end

endmodule

// File: rtl/fp16_add_mul.sv
// Registered binary16 a+b / a*b unit, one result per cycle, 1-cycle latency, FTZ + RNE.
// Add and multiply paths share one round/pack stage; specials override its result.
module fp16_add_mul
  import fp16_pkg::*;
(
  input logic           clk,
  input logic           rst,
  fp16_add_mul_if.slave bus
);

  fp16_t       a, b, rp_res, result;
  logic        za, zb, infa, infb, nana, nanb, is_mul;
  logic [10:0] ma, mb;

  assign a      = bus.a;
  assign b      = bus.b;
  assign is_mul = (bus.op == OP_MUL);
  assign za     = (a.exp == 5'd0);
  assign zb     = (b.exp == 5'd0);
  assign infa   = (a.exp == 5'h1f) && (a.frac == '0);
  assign infb   = (b.exp == 5'h1f) && (b.frac == '0);
  assign nana   = (a.exp == 5'h1f) && (a.frac != '0);
  assign nanb   = (b.exp == 5'h1f) && (b.frac != '0);
  assign ma     = za ? 11'd0 : {1'b1, a.frac};
  assign mb     = zb ? 11'd0 : {1'b1, b.frac};

  logic              swap, eff_sub, big_sign, lost;
  logic [4:0]        big_exp, sml_exp, d, lz;
  logic [10:0]       mbig, msml;
  logic [24:0]       sml_al;
  logic [25:0]       sum, nrm;
  logic              add_sign, add_zero;
  logic signed [7:0] add_exp;
  logic [13:0]       add_sig;

  always_comb begin
    swap     = {b.exp, mb} > {a.exp, ma};
    big_sign = swap ? b.sign : a.sign;
    big_exp  = swap ? b.exp : a.exp;
    sml_exp  = swap ? a.exp : b.exp;
    mbig     = swap ? mb : ma;
    msml     = swap ? ma : mb;
    d        = big_exp - sml_exp;
    // bits shifted past the LSB are jammed into it; 14 extension bits keep G/R exact
    lost     = |({7'b0, msml, 14'b0} & ((32'd1 << d) - 32'd1));
    sml_al   = ({msml, 14'b0} >> d) | {24'b0, lost};
    eff_sub  = a.sign ^ b.sign;
    sum      = eff_sub ? ({1'b0, mbig, 14'b0} - {1'b0, sml_al})
                       : ({1'b0, mbig, 14'b0} + {1'b0, sml_al});
    lz = 5'd0;
    for (int i = 0; i < 26; i++) begin
      if (sum[i]) lz = 5'(25 - i);
    end
    nrm      = sum << lz;
    add_zero = (sum == '0);
    add_sign = add_zero ? (a.sign & ~eff_sub) : big_sign;
    add_exp  = $signed({3'b000, big_exp}) - 8'sd14 - $signed({3'b000, lz});
    add_sig  = {nrm[25:15], nrm[14], nrm[13], |nrm[12:0]};
  end

  logic [21:0]       prod;
  logic              mul_sign, mul_zero;
  logic signed [7:0] mul_exp;
  logic [13:0]       mul_sig;

  always_comb begin
    prod     = {11'b0, ma} * {11'b0, mb};
    mul_zero = za | zb;
    mul_sign = a.sign ^ b.sign;
    mul_exp  = $signed({3'b000, a.exp}) + $signed({3'b000, b.exp}) - 8'sd30
             + (prod[21] ? 8'sd1 : 8'sd0);
    mul_sig  = prod[21] ? {prod[21:11], prod[10], prod[9], |prod[8:0]}
                        : {prod[20:10], prod[9],  prod[8], |prod[7:0]};
  end

  fp16_round_pack u_round_pack (
    .sign (is_mul ? mul_sign : add_sign),
    .zero (is_mul ? mul_zero : add_zero),
    .exp  (is_mul ? mul_exp  : add_exp),
    .sig  (is_mul ? mul_sig  : add_sig),
    .res  (rp_res)
  );

  always_comb begin
    result = rp_res;
    if (is_mul) begin
      if (nana | nanb | (infa & zb) | (infb & za)) result = QNAN;
      else if (infa | infb)                        result = mul_sign ? NEG_INF : POS_INF;
    end else begin
      if (nana | nanb | (infa & infb & eff_sub))   result = QNAN;
      else if (infa)                               result = a;
      else if (infb)                               result = b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.s         <= '0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) bus.s <= result;
    end
  end

endmodule

// File: tb/tb_fp16_add_mul.sv
// Directed and streaming checks of fp16_add_mul against hand values and a real-arithmetic model.
module tb_fp16_add_mul;
  import fp16_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [15:0] exp_last;

  fp16_add_mul_if bus ();

  fp16_add_mul dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic v, input logic o, input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    bus.in_valid = v;
    bus.op       = o;
    bus.a        = x;
    bus.b        = y;
    @(posedge clk);
    #1;
  endtask

  task automatic vec(input string tag, input logic o, input logic [15:0] x,
                     input logic [15:0] y, input logic [15:0] expv);
    drive(1'b1, o, x, y);
    check({tag, " valid"}, {15'b0, bus.out_valid}, 16'd1);
    check(tag, bus.s, expv);
  endtask

  function automatic real fp_to_real(input logic [15:0] x);
    logic [63:0] d;
    if (x[14:10] == 5'd0) d = {x[15], 63'b0};
    else d = {x[15], {6'b0, x[14:10]} + 11'd1008, x[9:0], 42'b0};
    return $bitstoreal(d);
  endfunction

  // Exact double result, then rounded to 11 significant bits (RNE) with unbounded
  // exponent, then overflow / flush-to-zero applied on the rounded exponent.
  function automatic logic [15:0] ref_model(input logic o, input logic [15:0] x, input logic [15:0] y);
    logic        zx, zy, ix, iy, nx, ny, sg;
    logic [63:0] d;
    logic [52:0] m;
    logic [41:0] rem;
    logic [11:0] rk;
    logic        up;
    int          be;
    real         r;
    zx = (x[14:10] == 5'd0);
    zy = (y[14:10] == 5'd0);
    ix = (x[14:10] == 5'h1f) && (x[9:0] == 10'd0);
    iy = (y[14:10] == 5'h1f) && (y[9:0] == 10'd0);
    nx = (x[14:10] == 5'h1f) && (x[9:0] != 10'd0);
    ny = (y[14:10] == 5'h1f) && (y[9:0] != 10'd0);
    if (o == OP_MUL) begin
      if (nx || ny || (ix && zy) || (iy && zx)) return QNAN;
      if (ix || iy) return (x[15] ^ y[15]) ? NEG_INF : POS_INF;
      r = fp_to_real(x) * fp_to_real(y);
    end else begin
      if (nx || ny || (ix && iy && (x[15] != y[15]))) return QNAN;
      if (ix) return x;
      if (iy) return y;
      r = fp_to_real(x) + fp_to_real(y);
    end
    d  = $realtobits(r);
    sg = d[63];
    if (d[62:0] == 63'd0) return {sg, 15'b0};
    m   = {1'b1, d[51:0]};
    rem = m[41:0];
    up  = (rem > 42'h200_0000_0000) || ((rem == 42'h200_0000_0000) && m[42]);
    rk  = {1'b0, m[52:42]} + {11'b0, up};
    be  = int'(d[62:52]) - 1023 + 15 + (rk[11] ? 1 : 0);
    if (be >= 31) return sg ? NEG_INF : POS_INF;
    if (be < 1)   return {sg, 15'b0};
    return {sg, be[4:0], rk[11] ? rk[10:1] : rk[9:0]};
  endfunction

  function automatic logic [15:0] rnd_operand();
    logic [15:0] x;
    x = 16'($urandom);
    if ($urandom_range(0, 1) == 1) x[14:10] = 5'($urandom_range(10, 20));
    return x;
  endfunction

  initial begin
    logic        v, o;
    logic [15:0] x, y;
    checks   = 0;
    errors   = 0;
    exp_last = 16'h0000;

    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.op       = OP_ADD;
    bus.a        = 16'h3C00;
    bus.b        = 16'h3C00;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("reset valid", {15'b0, bus.out_valid}, 16'd0);
      check("reset s", bus.s, 16'h0000);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("first after reset valid", {15'b0, bus.out_valid}, 16'd1);
    check("first after reset s", bus.s, 16'h4000);

    vec("add 1+1",          OP_ADD, 16'h3C00, 16'h3C00, 16'h4000);
    vec("mul 2*3",          OP_MUL, 16'h4000, 16'h4200, 16'h4600);
    vec("add 1-1",          OP_ADD, 16'h3C00, 16'hBC00, 16'h0000);
    vec("add -0+-0",        OP_ADD, 16'h8000, 16'h8000, 16'h8000);
    vec("add tie even",     OP_ADD, 16'h3C00, 16'h1000, 16'h3C00);
    vec("add tie odd",      OP_ADD, 16'h3C01, 16'h1000, 16'h3C02);
    vec("mul overflow",     OP_MUL, 16'h7BFF, 16'h4000, 16'h7C00);
    vec("mul underflow",    OP_MUL, 16'h0400, 16'h0400, 16'h0000);
    vec("add subnormal",    OP_ADD, 16'h0001, 16'h3C00, 16'h3C00);
    vec("mul inf*0",        OP_MUL, 16'h7C00, 16'h0000, 16'h7E00);
    vec("add inf-inf",      OP_ADD, 16'h7C00, 16'hFC00, 16'h7E00);
    vec("add nan+1",        OP_ADD, 16'h7E00, 16'h3C00, 16'h7E00);
    vec("mul -inf*2",       OP_MUL, 16'hFC00, 16'h4000, 16'hFC00);

    drive(1'b0, OP_ADD, 16'h3C00, 16'h3C00);
    check("idle valid", {15'b0, bus.out_valid}, 16'd0);
    check("idle hold s", bus.s, 16'hFC00);
    exp_last = 16'hFC00;

    for (int i = 0; i < 1000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      o = i[0];
      x = rnd_operand();
      y = rnd_operand();
      drive(v, o, x, y);
      check("stream valid", {15'b0, bus.out_valid}, {15'b0, v});
      if (v) exp_last = ref_model(o, x, y);
      check(o ? "stream mul" : "stream add", bus.s, exp_last);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp16_add_mul.md
Name: fp16_add_mul

Overview:
- Registered IEEE-754 binary16 (half-precision) arithmetic unit that computes either a+b or a*b on one operand pair per cycle.
- Used as the arithmetic core of the fp16 multiply-accumulate datapath in the inference engine.
- Combinational add and multiply paths feed a shared normalise/round/pack stage; the result is registered with a valid flag.

Parameters:
- None. The format is fixed: 1 sign bit, 5 exponent bits (bias 15), 10 fraction bits.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operand pair present this cycle
- op  in  1  0 = add (a+b), 1 = multiply (a*b)
- a  in  16  operand A, binary16
- b  in  16  operand B, binary16
- out_valid  out  1  s holds a new result
- s  out  16  result, binary16

Behaviour:
- Reset: on a clk edge with rst=1, out_valid<=0 and s<=16'h0000. rst has priority over in_valid.
- Latency: exactly 1 cycle.
  - in_valid=1 at edge N gives out_valid=1 and s=f(a,b,op) after edge N.
  - in_valid=0 at an edge gives out_valid<=0; s holds its previous value.
  - Back-to-back operation is supported, with throughput 1 per cycle.
- No handshake or stall; no backpressure.
- Subnormals are flushed to zero (FTZ):
  - an input with exp=0 is treated as zero of the same sign;
  - any result whose biased exponent is below 1 after rounding becomes signed zero.
- Rounding: round-to-nearest, ties-to-even, using guard, round and sticky bits.
- Overflow: biased exponent of 31 or more after rounding gives signed infinity (16'h7C00 or 16'hFC00).
- NaN: any NaN input, Inf-Inf (add), or Inf*0 (mul) yields the canonical quiet NaN 16'h7E00.
- Infinity rules:
  - Inf + finite = Inf;
  - Inf + Inf of the same sign = Inf;
  - Inf * nonzero finite = Inf, with sign = sa^sb.
- Add:
  - align the smaller-magnitude operand by right-shifting its significand (hidden 1 restored); bits shifted out fold into sticky;
  - add or subtract magnitudes according to the signs;
  - renormalise with a leading-zero count (left shift) or a 1-bit right shift on carry-out.
- Add, signed-zero rules:
  - an exact-zero result from operands of opposite sign is +0;
  - (-0)+(-0) = -0.
- Multiply:
  - sign = sa^sb;
  - exponent = ea+eb-15;
  - 11x11 significand product (22 bits), normalised by at most a 1-bit shift;
  - zero times finite = signed zero.
- Output register only; no internal state beyond s and out_valid.

Decomposition:
- Package fp16_pkg holds:
  - constants: EXP_W=5, FRAC_W=10, BIAS=15, QNAN=16'h7E00, POS_INF=16'h7C00, NEG_INF=16'hFC00;
  - typedef fp16_t, a packed struct {sign, exp[4:0], frac[9:0]};
  - op encoding constants OP_ADD=1'b0 and OP_MUL=1'b1.
- One combinational sub-module, fp16_round_pack:
  - takes sign, an unbiased exponent with extended width, and a significand with guard/round/sticky bits;
  - performs rounding, overflow to Inf, FTZ underflow and packing;
  - is shared by the add and mul paths via an op mux ahead of it.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 and arbitrary operands -> out_valid=0 and s=16'h0000; the first result appears 1 cycle after rst falls.
- Basic add/mul:
  - add 16'h3C00+16'h3C00 -> 16'h4000;
  - mul 16'h4000*16'h4200 -> 16'h4600;
  - add 16'h3C00+16'hBC00 -> 16'h0000;
  - add 16'h8000+16'h8000 -> 16'h8000;
  - each result follows its in_valid edge by exactly 1 cycle.
- Rounding ties:
  - add 16'h3C00+16'h1000 (1+2^-11) -> 16'h3C00;
  - add 16'h3C01+16'h1000 -> 16'h3C02.
- Overflow/underflow:
  - mul 16'h7BFF*16'h4000 -> 16'h7C00;
  - mul 16'h0400*16'h0400 -> 16'h0000 (FTZ);
  - add 16'h0001 (subnormal)+16'h3C00 -> 16'h3C00.
- Specials:
  - mul 16'h7C00*16'h0000 -> 16'h7E00;
  - add 16'h7C00+16'hFC00 -> 16'h7E00;
  - add 16'h7E00+16'h3C00 -> 16'h7E00;
  - mul 16'hFC00*16'h4000 -> 16'hFC00.
- Streaming: alternate op every cycle for 1000 random operand pairs with in_valid randomly toggled -> every out_valid result matches a reference model under the FTZ/RNE rules; s is stable while out_valid=0.
